// File: rtl/otter_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : otter_store_unit
//  Purpose  : Write-side store path for OTTER memory port 2. Takes one CPU
//             store (byte/half/word) per valid/ready handshake and turns it
//             into one or two word-aligned write beats with byte enables.
//             A store that straddles a word boundary becomes two back-to-back
//             beats. MEM_BUSY2 stalls the current beat.
//  Ports    :
//    CLK, RESET          clock, synchronous active-high reset
//    ST_VALID/ST_READY   store request handshake
//    ST_ADDR/DATA/SIZE   byte address, right-justified data, size code
//    ST_ERR              one-cycle pulse after an illegal size is accepted
//    MEM_WE2/ADDR2/DIN2  write strobe, word address, lane-aligned data
//    MEM_BE2             byte enables (bit i -> lane [8i+7:8i])
//    MEM_BUSY2           memory back-pressure
//    IDLE_O              no store pending
//  Revision : 1.0 - initial release
// ============================================================================
module otter_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ST_VALID,
  output logic                ST_READY,
  input  logic [ADDR_W-1:0]   ST_ADDR,
  input  logic [DATA_W-1:0]   ST_DATA,
  input  logic [1:0]          ST_SIZE,
  output logic                ST_ERR,
  output logic                MEM_WE2,
  output logic [ADDR_W-1:0]   MEM_ADDR2,
  output logic [DATA_W-1:0]   MEM_DIN2,
  output logic [DATA_W/8-1:0] MEM_BE2,
  input  logic                MEM_BUSY2,
  output logic                IDLE_O
);

  localparam int c_BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2
  } state_t;

  state_t r_state, w_state;

  logic               r_we, w_we;
  logic [ADDR_W-1:0]  r_addr, w_addr;
  logic [DATA_W-1:0]  r_din, w_din;
  logic [c_BE_W-1:0]  r_be, w_be;
  logic               r_err, w_err;
  logic               r_ready, w_ready;
  logic               r_idle, w_idle;

  // Second-beat holding registers, filled at accept time.
  logic [ADDR_W-1:0]  r_hi_addr, w_hi_addr;
  logic [DATA_W-1:0]  r_hi_din, w_hi_din;
  logic [c_BE_W-1:0]  r_hi_be, w_hi_be;

  // Lane math on the incoming request: a double-width mask and data image,
  // low half is beat 1, high half is beat 2.
  logic [1:0]          w_off;
  logic [2*c_BE_W-1:0] w_base_mask;
  logic [2*c_BE_W-1:0] w_mask;
  logic [2*DATA_W-1:0] w_data2;
  logic [ADDR_W-1:0]   w_addr1;

  always_comb begin
    w_off = ST_ADDR[1:0];
    case (ST_SIZE)
      2'b00:   w_base_mask = 8'b0000_0001;
      2'b01:   w_base_mask = 8'b0000_0011;
      2'b10:   w_base_mask = 8'b0000_1111;
      default: w_base_mask = 8'b0000_0000;
    endcase
    w_mask  = w_base_mask << w_off;
    w_data2 = {{DATA_W{1'b0}}, ST_DATA} << {w_off, 3'b000};
    w_addr1 = {ST_ADDR[ADDR_W-1:2], 2'b00};
  end

  always_comb begin
    w_state   = r_state;
    w_we      = r_we;
    w_addr    = r_addr;
    w_din     = r_din;
    w_be      = r_be;
    w_err     = 1'b0;
    w_hi_addr = r_hi_addr;
    w_hi_din  = r_hi_din;
    w_hi_be   = r_hi_be;

    case (r_state)
      S_IDLE: begin
        if (ST_VALID && r_ready) begin
          if (ST_SIZE == 2'b11) begin
            // Illegal size is consumed without touching memory.
            w_err = 1'b1;
          end else begin
            w_state   = S_BEAT1;
            w_we      = 1'b1;
            w_addr    = w_addr1;
            w_din     = w_data2[DATA_W-1:0];
            w_be      = w_mask[c_BE_W-1:0];
            // Wraps modulo 2^ADDR_W at the top of the address space.
            w_hi_addr = w_addr1 + ADDR_W'(4);
            w_hi_din  = w_data2[2*DATA_W-1:DATA_W];
            w_hi_be   = w_mask[2*c_BE_W-1:c_BE_W];
          end
        end
      end
      S_BEAT1: begin
        if (!MEM_BUSY2) begin
          if (r_hi_be != '0) begin
            w_state = S_BEAT2;
            w_addr  = r_hi_addr;
            w_din   = r_hi_din;
            w_be    = r_hi_be;
          end else begin
            w_state = S_IDLE;
            w_we    = 1'b0;
            w_be    = '0;
          end
        end
      end
      S_BEAT2: begin
        if (!MEM_BUSY2) begin
          w_state = S_IDLE;
          w_we    = 1'b0;
          w_be    = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_we    = 1'b0;
        w_be    = '0;
      end
    endcase

    w_ready = (w_state == S_IDLE);
    w_idle  = (w_state == S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_be      <= '0;
      r_err     <= 1'b0;
      r_ready   <= 1'b1;
      r_idle    <= 1'b1;
      r_hi_addr <= '0;
      r_hi_din  <= '0;
      r_hi_be   <= '0;
    end else begin
      r_state   <= w_state;
      r_we      <= w_we;
      r_addr    <= w_addr;
      r_din     <= w_din;
      r_be      <= w_be;
      r_err     <= w_err;
      r_ready   <= w_ready;
      r_idle    <= w_idle;
      r_hi_addr <= w_hi_addr;
      r_hi_din  <= w_hi_din;
      r_hi_be   <= w_hi_be;
    end
  end

  assign ST_READY  = r_ready;
  assign ST_ERR    = r_err;
  assign MEM_WE2   = r_we;
  assign MEM_ADDR2 = r_addr;
  assign MEM_DIN2  = r_din;
  assign MEM_BE2   = r_be;
  assign IDLE_O    = r_idle;

endmodule
`default_nettype wire

// File: doc/otter_store_unit.md
Name: otter_store_unit

Overview:
- Write-side counterpart to the instruction fetch path; drives memory port 2 of the OTTER memory with CPU store traffic.
- Accepts one store request at a time (byte, half or word) through a valid/ready handshake.
- Converts each request into word-aligned write beats with byte enables.
- Splits a store that crosses a word boundary into two consecutive beats; honours memory back-pressure.

Parameters:
- ADDR_W, 32, address width of the CPU and memory ports.
- DATA_W, 32, data width; fixed at 32, with byte enables 4 bits wide.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ST_VALID  input  1  store request present.
- ST_READY  output  1  unit can accept a request this cycle.
- ST_ADDR  input  32  byte address of the store.
- ST_DATA  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- ST_SIZE  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- ST_ERR  output  1  one-cycle pulse when an illegal size is accepted.
- MEM_WE2  output  1  write strobe to memory port 2.
- MEM_ADDR2  output  32  word-aligned write address; bits [1:0] always 00.
- MEM_DIN2  output  32  write data, lane-aligned.
- MEM_BE2  output  4  byte enables; bit i enables byte lane [8i+7:8i].
- MEM_BUSY2  input  1  memory cannot take a write this cycle.
- IDLE_O  output  1  high when no store is pending, for pipeline drain and fence logic.

Behaviour:
- Reset values: state IDLE; ST_READY=1; ST_ERR=0; MEM_WE2=0; MEM_ADDR2=0; MEM_DIN2=0; MEM_BE2=0000; IDLE_O=1.
- States: IDLE, BEAT1, BEAT2. All outputs are registered.
- ST_READY=1 only in IDLE. A request is accepted when ST_VALID & ST_READY at a rising edge. ADDR, DATA and SIZE are captured into holding registers.
- Lane math on capture, with off = ST_ADDR[1:0]:
  - 8-bit mask: byte 0001, half 0011, word 1111, shifted left by off.
  - 64-bit data: zero-extended ST_DATA shifted left by 8*off.
  - Low halves form beat 1 at {ST_ADDR[31:2],00}.
  - High halves form beat 2 at beat-1 address + 4. The address wraps modulo 2^32, so 0xFFFFFFFC + 4 gives 0x00000000.
- Beat 2 exists only if the high mask half is nonzero (a half at off 3, or a word at off 1..3).
- Latency: accept at edge N; beat 1 is presented (MEM_WE2=1) in the cycle after edge N.
- BEAT1: if MEM_BUSY2=1, hold all outputs and stay in BEAT1. Otherwise the beat completes at this edge, and the next state is:
  - BEAT2 if a second beat exists, with outputs loaded for beat 2;
  - IDLE otherwise, with MEM_WE2=0 and MEM_BE2=0000.
- BEAT2: same stall rule. On completion go to IDLE and deassert MEM_WE2.
- Throughput: aligned store takes 2 cycles from accept to next accept; split store takes 3 cycles (plus stall cycles).
- Illegal size (11): the request is accepted, no memory write is issued, ST_ERR pulses for the cycle after accept, and the state stays IDLE (ST_READY remains 1).
- Outputs while MEM_WE2=0: MEM_ADDR2 and MEM_DIN2 hold their last value; MEM_BE2 is 0000.
- IDLE_O equals (state==IDLE).
- Reset mid-operation: a pending beat is dropped. The next cycle shows reset values, and no partial second beat is ever issued.
- MEM_BUSY2 is ignored in IDLE.
- ST_ADDR, ST_DATA and ST_SIZE are don't-care when not accepted. A ST_VALID held while busy is not accepted until ST_READY=1.

Test Plan:
- Word store, ADDR=0x00000104, DATA=0xDEADBEEF, SIZE=10 -> one beat: ADDR2=0x00000104, DIN2=0xDEADBEEF, BE2=1111. ST_READY is low for exactly one cycle.
- Byte store, ADDR=0x00000203, DATA=0x000000A5, SIZE=00 -> one beat: ADDR2=0x00000200, DIN2=0xA5000000, BE2=1000.
- Misaligned word, ADDR=0x00000302, DATA=0x11223344, SIZE=10 -> two beats on consecutive cycles:
  - beat 1: 0x00000300 / 0x33440000 / BE 1100;
  - beat 2: 0x00000304 / 0x00001122 / BE 0011.
- Half store at ADDR=0xFFFFFFFF, DATA=0xBEEF, with MEM_BUSY2 high for 3 cycles during beat 1 -> beat 1 held 4 cycles (0xFFFFFFFC / 0xEF000000 / BE 1000), then beat 2 at 0x00000000 / 0x000000BE / BE 0001.
- SIZE=11 at any address -> ST_ERR pulses one cycle, MEM_WE2 never asserts, and a following valid word store is accepted the next cycle.
- RESET asserted during BEAT1 of a split store -> MEM_WE2=0 and ST_READY=1 the following cycle, and no beat 2 ever appears.
